softmax_pkt_buffer: RTL and testbench

Parametrised packet buffer for the softmax datapath. It collects one vector (packet) from the upstream stage, then replays the stored packet NUM_PASS times to the downstream stage (max pass, exp/sum pass, normalise pass). The output is a full valid/ready stream: valid holds until accepted, and each beat carries last and pass-index tags.

---
 rtl/softmax_pkt_buffer.sv | 142 ++++++++++++++
 tb/tb_softmax_pkt_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_pkt_buffer.sv
// Packet buffer for the softmax datapath: stores one packet from upstream, then
// replays it NUM_PASS times downstream as a valid/ready stream with last/pass tags.
module softmax_pkt_buffer #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_PASS = 3,
  parameter int PASS_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [PASS_W-1:0] m_pass_o,
  input  logic              m_ready_i,
  output logic [ADDR_W:0]   len_o,
  output logic              busy_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {COLLECT, LOAD, DRAIN} state_t;

  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_reg, rd_reg, rd_next, rd_addr;
  logic [PASS_W-1:0] pass_reg, pass_next;
  logic [ADDR_W:0]   len_reg;
  logic              m_valid_reg, m_last_reg, ovf_reg;
  logic [DATA_W-1:0] m_data_reg;

  logic s_fire, pkt_end, out_adv, pass_end, done;

  always_comb begin
    s_fire    = s_valid_i && (state_reg == COLLECT);
    pkt_end   = s_fire && (s_last_i || (wr_reg == WR_LAST));
    out_adv   = (state_reg == DRAIN) && (!m_valid_reg || m_ready_i);
    pass_end  = ({1'b0, rd_reg} == (len_reg - LEN_ONE));
    done      = out_adv && m_valid_reg && pass_end && (pass_reg == PASS_LAST);
    rd_next   = pass_end ? '0 : rd_reg + ADDR_W'(1);
    pass_next = pass_end ? pass_reg + PASS_W'(1) : pass_reg;
    // LOAD always fetches the first element; DRAIN prefetches the next beat
    rd_addr   = (state_reg == LOAD) ? '0 : rd_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = COLLECT;
    end else begin
      case (state_reg)
        COLLECT: if (pkt_end) state_next = LOAD;
        LOAD:    state_next = DRAIN;
        DRAIN:   if (done) state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= COLLECT;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (s_fire && !flush_i) mem[wr_reg] <= s_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg      <= '0;
      rd_reg      <= '0;
      pass_reg    <= '0;
      len_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
    end else if (flush_i) begin
      wr_reg      <= '0;
      rd_reg      <= '0;
      pass_reg    <= '0;
      len_reg     <= '0;
      m_valid_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (pkt_end) begin
            wr_reg  <= '0;
            len_reg <= {1'b0, wr_reg} + LEN_ONE;
            if (!s_last_i) ovf_reg <= 1'b1;
          end else if (s_fire) begin
            wr_reg <= wr_reg + ADDR_W'(1);
          end
        end
        LOAD: begin
          m_data_reg  <= mem[rd_addr];
          rd_reg      <= '0;
          pass_reg    <= '0;
          m_last_reg  <= (len_reg == LEN_ONE);
          m_valid_reg <= 1'b1;
        end
        DRAIN: begin
          if (done) begin
            m_valid_reg <= 1'b0;
            len_reg     <= '0;
            rd_reg      <= '0;
            pass_reg    <= '0;
          end else if (out_adv) begin
            m_data_reg  <= mem[rd_addr];
            rd_reg      <= rd_next;
            pass_reg    <= pass_next;
            m_last_reg  <= ({1'b0, rd_next} == (len_reg - LEN_ONE));
            m_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready_o = (state_reg == COLLECT);
  assign busy_o    = (state_reg != COLLECT);
  assign m_valid_o = m_valid_reg;
  assign m_data_o  = m_data_reg;
  assign m_last_o  = m_last_reg;
  assign m_pass_o  = pass_reg;
  assign len_o     = len_reg;
  assign ovf_o     = ovf_reg;

endmodule

// File: tb/tb_softmax_pkt_buffer.sv
// Directed bench: a queue of expected beats per packet is checked against every
// accepted output beat, plus literal checks on timing, flags and flush/reset.
module tb_softmax_pkt_buffer;
  localparam int DATA_W = 32, DEPTH = 64, ADDR_W = 6, NUM_PASS = 3, PASS_W = 2;

  logic clk = 0, rst_n = 0, flush = 0;
  logic s_valid = 0, s_last = 0, s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic m_valid, m_last, m_ready;
  logic [DATA_W-1:0] m_data;
  logic [PASS_W-1:0] m_pass;
  logic [ADDR_W:0] len;
  logic busy, ovf;

  softmax_pkt_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                       .NUM_PASS(NUM_PASS), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_pass_o(m_pass),
    .m_ready_i(m_ready), .len_o(len), .busy_o(busy), .ovf_o(ovf));

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] data; logic last; logic [PASS_W-1:0] pass; } beat_t;
  beat_t exp_q[$];

  int n_cmp = 0, n_fail = 0, beat_cnt = 0, model_len = 0;
  bit toggle_mode = 0, prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;
  logic [PASS_W-1:0] prev_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats from the packet rules: stored length, then NUM_PASS replays.
  task automatic build_model(input logic [DATA_W-1:0] base, input int n, input bit use_last);
    int l = 0;
    beat_t b;
    for (int i = 0; i < n; i++) begin
      l++;
      if (use_last && i == n - 1) break;
      if (i == DEPTH - 1) break;
    end
    model_len = l;
    for (int p = 0; p < NUM_PASS; p++)
      for (int i = 0; i < l; i++) begin
        b.data = base + DATA_W'(i);
        b.last = (i == l - 1);
        b.pass = PASS_W'(p);
        exp_q.push_back(b);
      end
  endtask

  task automatic send(input int n, input bit use_last, input logic [DATA_W-1:0] base,
                      output int acc);
    bit hs;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = base + DATA_W'(i); s_last = use_last && (i == n - 1);
      @(negedge clk); hs = s_ready;
      @(posedge clk); #1;
      if (!hs) break;
      acc++;
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic post_done(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_len"}, len, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk); #1;
      m_ready = toggle_mode ? ~m_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n || flush) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
        chk("stall_pass", m_pass, prev_pass);
      end
      if (m_valid) begin
        chk("busy_drain", busy, 1);
        chk("len_drain", len, model_len);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", m_data);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", m_data, b.data);
          chk("beat_last", m_last, b.last);
          chk("beat_pass", m_pass, b.pass);
          beat_cnt++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data; prev_last = m_last; prev_pass = m_pass;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, cyc, b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_len", len, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_pass", m_pass, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // 4-element packet, ready held high
    send(4, 1, 'h10, acc);
    build_model('h10, 4, 1);
    chk("s1_accepted", acc, 4);
    chk("s1_ready_drop", s_ready, 0);
    chk("s1_valid_load", m_valid, 0);
    chk("s1_len_load", len, 4);
    @(posedge clk); #1;
    chk("s1_first_valid", m_valid, 1);
    chk("s1_first_data", m_data, 'h10);
    chk("s1_first_pass", m_pass, 0);
    wait_drain(cyc);
    chk("s1_no_bubbles", cyc, 12);
    post_done("s1");

    // Same packet, ready toggling
    toggle_mode = 1;
    send(4, 1, 'h10, acc);
    build_model('h10, 4, 1);
    chk("s2_accepted", acc, 4);
    wait_drain(cyc);
    toggle_mode = 0;
    @(posedge clk); #1;
    post_done("s2");

    // 70 elements without last: truncation at DEPTH
    send(70, 0, 'h100, acc);
    build_model('h100, 70, 0);
    chk("s3_accepted", acc, 64);
    chk("s3_ovf", ovf, 1);
    chk("s3_len", len, 64);
    wait_drain(cyc);
    post_done("s3");
    send(2, 1, 'h200, acc);
    build_model('h200, 2, 1);
    chk("s3b_accepted", acc, 2);
    chk("s3b_ovf_sticky", ovf, 1);
    wait_drain(cyc);
    post_done("s3b");

    // single-element packet
    send(1, 1, 'hAB, acc);
    build_model('hAB, 1, 1);
    @(posedge clk); #1;
    chk("s4_valid", m_valid, 1);
    chk("s4_last", m_last, 1);
    wait_drain(cyc);
    chk("s4_back_to_back", cyc, 3);
    post_done("s4");

    // flush during pass 1, second beat
    send(4, 1, 'h20, acc);
    build_model('h20, 4, 1);
    b0 = beat_cnt; cyc = 0;
    while (beat_cnt - b0 < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("s5_pres_pass", m_pass, 1);
    chk("s5_pres_data", m_data, 'h21);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    exp_q.delete();
    chk("s5_valid", m_valid, 0);
    chk("s5_s_ready", s_ready, 1);
    chk("s5_len", len, 0);
    chk("s5_ovf", ovf, 0);
    send(3, 1, 'h30, acc);
    build_model('h30, 3, 1);
    chk("s5b_accepted", acc, 3);
    wait_drain(cyc);
    chk("s5b_cycles", cyc, 10);
    post_done("s5b");

    // async reset in the middle of DRAIN
    send(3, 1, 'h40, acc);
    build_model('h40, 3, 1);
    b0 = beat_cnt; cyc = 0;
    while (beat_cnt - b0 < 4 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    rst_n = 0;
    #1;
    chk("s6_async_valid", m_valid, 0);
    chk("s6_async_pass", m_pass, 0);
    chk("s6_async_len", len, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("s6_valid", m_valid, 0);
    chk("s6_s_ready", s_ready, 1);
    send(2, 1, 'h50, acc);
    build_model('h50, 2, 1);
    chk("s6b_ready_drop", s_ready, 0);
    chk("s6b_valid_load", m_valid, 0);
    @(posedge clk); #1;
    chk("s6b_first_valid", m_valid, 1);
    chk("s6b_first_data", m_data, 'h50);
    wait_drain(cyc);
    chk("s6b_no_bubbles", cyc, 6);
    post_done("s6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
